// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_pkg
// Purpose  : Note constants, channel ids, FSM states and the default note ROM.
// Revision : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam int TONE_CH      = 6;
    localparam int TONE_NOTES   = 4;
    localparam int TONE_PS_W    = 10;
    localparam int TONE_DUR_W   = 4;
    localparam int TONE_ENTRY_W = TONE_PS_W + TONE_DUR_W;

    localparam logic [TONE_PS_W-1:0] DO  = 10'h175;
    localparam logic [TONE_PS_W-1:0] RE  = 10'h14C;
    localparam logic [TONE_PS_W-1:0] MI  = 10'h128;
    localparam logic [TONE_PS_W-1:0] FA  = 10'h117;
    localparam logic [TONE_PS_W-1:0] SOL = 10'h0F9;
    localparam logic [TONE_PS_W-1:0] LA  = 10'h0DD;
    localparam logic [TONE_PS_W-1:0] SI  = 10'h18B;

    localparam int ENTER  = 0;
    localparam int KEY_X  = 1;
    localparam int KEY_Y  = 2;
    localparam int HOLE   = 3;
    localparam int BORDER = 4;
    localparam int BALL   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [TONE_ENTRY_W-1:0] NO_NOTE = '0;

    // Flat table, entry k = channel*TONE_NOTES + note lives at bits [k*14 +: 14].
    localparam logic [TONE_CH*TONE_NOTES*TONE_ENTRY_W-1:0] DEFAULT_ROM = {
        NO_NOTE, NO_NOTE,     NO_NOTE,      {FA, 4'd2},     // BALL
        NO_NOTE, NO_NOTE,     NO_NOTE,      {SI, 4'd2},     // BORDER
        NO_NOTE, {DO, 4'd6},  {SOL, 4'd3},  {LA, 4'd3},     // HOLE
        NO_NOTE, NO_NOTE,     NO_NOTE,      {MI, 4'd2},     // KEY_Y
        NO_NOTE, NO_NOTE,     NO_NOTE,      {RE, 4'd2},     // KEY_X
        NO_NOTE, NO_NOTE,     NO_NOTE,      {DO, 4'd2}      // ENTER
    };

endpackage : tone_pkg
`default_nettype wire

// File: rtl/tone_rom.sv
`default_nettype none
// ============================================================================
// Module   : tone_rom
// Purpose  : Combinational (channel, note) -> {prescale, duration} lookup.
// Revision : 1.0 - initial release
// ============================================================================
module tone_rom
    import tone_pkg::*;
#(
    parameter int NUM_REQ    = TONE_CH,
    parameter int MAX_NOTES  = TONE_NOTES,
    parameter int PRESCALE_W = TONE_PS_W,
    parameter int DUR_W      = TONE_DUR_W,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int IDX_W      = $clog2(MAX_NOTES),
    parameter logic [NUM_REQ*MAX_NOTES*(PRESCALE_W+DUR_W)-1:0] ROM = DEFAULT_ROM
) (
    input  logic [ID_W-1:0]       channel,
    input  logic [IDX_W-1:0]      note_idx,
    output logic [PRESCALE_W-1:0] prescale,
    output logic [DUR_W-1:0]      dur
);

    localparam int ENTRY_W = PRESCALE_W + DUR_W;

    logic [ENTRY_W-1:0] table_mem [NUM_REQ][MAX_NOTES];
    logic [ENTRY_W-1:0] entry;

    for (genvar c = 0; c < NUM_REQ; c++) begin : g_chan
        for (genvar n = 0; n < MAX_NOTES; n++) begin : g_note
            assign table_mem[c][n] = ROM[(c*MAX_NOTES + n)*ENTRY_W +: ENTRY_W];
        end
    end

    // Channel ids beyond NUM_REQ read back as a terminator.
    always_comb begin
        entry = '0;
        if (channel <= ID_W'(NUM_REQ - 1)) begin
            entry = table_mem[channel][note_idx];
        end
    end

    assign {prescale, dur} = entry;

endmodule : tone_rom
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Priority arbiter for sound requests and frame-timed note player.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int NUM_REQ    = 6,
    parameter int MAX_NOTES  = 4,
    parameter int PRESCALE_W = 10,
    parameter int DUR_W      = 4,
    parameter int GAP_FRAMES = 1,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [NUM_REQ-1:0]    audioRequest,
    input  logic                  mute,
    output logic [PRESCALE_W-1:0] preScaleValue,
    output logic                  busy,
    output logic [ID_W-1:0]       activeId,
    output logic                  seqDone
);

    localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NOTES - 1);

    state_t                  state, state_nx;
    logic [NUM_REQ-1:0]      pending, pending_nx;
    logic [IDX_W-1:0]        note_idx, note_idx_nx, next_idx;
    logic [DUR_W-1:0]        frame_cnt, frame_cnt_nx;
    logic [GAP_W-1:0]        gap_cnt, gap_cnt_nx;
    logic [PRESCALE_W-1:0]   tone, tone_nx;
    logic [ID_W-1:0]         id_nx;
    logic                    done_nx;

    logic [NUM_REQ-1:0]      active_mask, cand, win_mask;
    logic [ID_W-1:0]         win_id, start_id;
    logic                    win_valid, preempt, retrig, launch, start;
    logic [PRESCALE_W-1:0]   start_ps, next_ps;
    logic [DUR_W-1:0]        start_dur, next_dur, start_dur_eff, next_dur_eff;
    logic                    next_valid;

    // Requests for the sounding channel retrigger it instead of queueing.
    always_comb begin
        active_mask = '0;
        if (state != IDLE) begin
            active_mask[activeId] = 1'b1;
        end
        cand     = pending | (audioRequest & ~active_mask);
        retrig   = (state != IDLE) && |(audioRequest & active_mask);
        win_mask = cand & (~cand + 1'b1);
        win_id   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
        win_valid = |cand;
        preempt   = (state != IDLE) && win_valid && (win_id < activeId);
        launch    = win_valid && ((state == IDLE) || preempt);
        start     = launch || retrig;
        start_id  = launch ? win_id : activeId;
        next_idx  = note_idx + 1'b1;
    end

    tone_rom #(
        .NUM_REQ    (NUM_REQ),
        .MAX_NOTES  (MAX_NOTES),
        .PRESCALE_W (PRESCALE_W),
        .DUR_W      (DUR_W),
        .ID_W       (ID_W),
        .IDX_W      (IDX_W)
    ) u_rom_start (
        .channel  (start_id),
        .note_idx ('0),
        .prescale (start_ps),
        .dur      (start_dur)
    );

    tone_rom #(
        .NUM_REQ    (NUM_REQ),
        .MAX_NOTES  (MAX_NOTES),
        .PRESCALE_W (PRESCALE_W),
        .DUR_W      (DUR_W),
        .ID_W       (ID_W),
        .IDX_W      (IDX_W)
    ) u_rom_next (
        .channel  (activeId),
        .note_idx (next_idx),
        .prescale (next_ps),
        .dur      (next_dur)
    );

    assign start_dur_eff = (start_dur == '0) ? DUR_W'(1) : start_dur;
    assign next_dur_eff  = (next_dur == '0) ? DUR_W'(1) : next_dur;
    assign next_valid    = (note_idx != LAST_IDX) && (next_ps != '0);

    always_comb begin
        state_nx     = state;
        pending_nx   = cand & ~(launch ? win_mask : '0);
        note_idx_nx  = note_idx;
        frame_cnt_nx = frame_cnt;
        gap_cnt_nx   = gap_cnt;
        tone_nx      = tone;
        id_nx        = activeId;
        done_nx      = 1'b0;

        // A launch swallows a coincident startOfFrame.
        if (start) begin
            id_nx        = start_id;
            note_idx_nx  = '0;
            frame_cnt_nx = start_dur_eff;
            gap_cnt_nx   = '0;
            if (start_ps == '0) begin
                tone_nx  = '0;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end else begin
                tone_nx  = start_ps;
                state_nx = PLAY;
            end
        end else if (startOfFrame) begin
            case (state)
                PLAY: begin
                    if (frame_cnt > DUR_W'(1)) begin
                        frame_cnt_nx = frame_cnt - 1'b1;
                    end else if (next_valid) begin
                        if (GAP_FRAMES > 0) begin
                            tone_nx    = '0;
                            gap_cnt_nx = GAP_W'(GAP_FRAMES);
                            state_nx   = GAP;
                        end else begin
                            note_idx_nx  = next_idx;
                            frame_cnt_nx = next_dur_eff;
                            tone_nx      = next_ps;
                        end
                    end else begin
                        tone_nx  = '0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt > GAP_W'(1)) begin
                        gap_cnt_nx = gap_cnt - 1'b1;
                    end else begin
                        note_idx_nx  = next_idx;
                        frame_cnt_nx = next_dur_eff;
                        tone_nx      = next_ps;
                        state_nx     = PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            note_idx      <= '0;
            frame_cnt     <= '0;
            gap_cnt       <= '0;
            tone          <= '0;
            preScaleValue <= '0;
            busy          <= 1'b0;
            activeId      <= '0;
            seqDone       <= 1'b0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            note_idx      <= note_idx_nx;
            frame_cnt     <= frame_cnt_nx;
            gap_cnt       <= gap_cnt_nx;
            tone          <= tone_nx;
            preScaleValue <= mute ? '0 : tone_nx;
            busy          <= (state_nx != IDLE);
            activeId      <= id_nx;
            seqDone       <= done_nx;
        end
    end

endmodule : tone_sequencer
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Purpose  : Directed self-checking bench for tone_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic [5:0] audioRequest = '0;
    logic       mute = 1'b0;
    logic [9:0] preScaleValue;
    logic       busy;
    logic [2:0] activeId;
    logic       seqDone;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (seqDone === 1'b1) done_cnt++;
    end

    tone_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .audioRequest  (audioRequest),
        .mute          (mute),
        .preScaleValue (preScaleValue),
        .busy          (busy),
        .activeId      (activeId),
        .seqDone       (seqDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_step();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int ch);
        audioRequest[ch] = 1'b1;
        step();
        audioRequest = '0;
    endtask

    // Expected tone after each frame edge of the HOLE sequence.
    logic [9:0] hole_exp [14] = '{10'h0DD, 10'h0DD, 10'h000, 10'h0F9, 10'h0F9, 10'h0F9, 10'h000,
                                  10'h175, 10'h175, 10'h175, 10'h175, 10'h175, 10'h175, 10'h000};

    initial begin
        step();
        reset = 1'b0;
        check("rst_ps", 32'(preScaleValue), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_id", 32'(activeId), 32'h0);
        check("rst_done", 32'(seqDone), 32'h0);
        idle(3);
        check("rst_idle_ps", 32'(preScaleValue), 32'h0);

        // Full HOLE sequence
        done_base = done_cnt;
        request(3);
        check("hole_launch_ps", 32'(preScaleValue), 32'h0DD);
        check("hole_launch_id", 32'(activeId), 32'h3);
        check("hole_launch_busy", 32'(busy), 32'h1);
        idle(9);
        for (int f = 0; f < 14; f++) begin
            sof_step();
            check($sformatf("hole_f%0d_ps", f), 32'(preScaleValue), 32'(hole_exp[f]));
            check($sformatf("hole_f%0d_done", f), 32'(seqDone), (f == 13) ? 32'h1 : 32'h0);
            idle(4);
            check($sformatf("hole_f%0d_mid", f), 32'(preScaleValue), 32'(hole_exp[f]));
            idle(5);
        end
        check("hole_busy_end", 32'(busy), 32'h0);
        check("hole_done_cnt", 32'(done_cnt - done_base), 32'h1);

        // Reset mid-PLAY; a request in the reset clock is dropped
        request(3);
        idle(9);
        sof_step();
        idle(3);
        reset = 1'b1;
        audioRequest[2] = 1'b1;
        step();
        reset = 1'b0;
        audioRequest = '0;
        check("mid_rst_ps", 32'(preScaleValue), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        idle(3);
        check("mid_rst_after_ps", 32'(preScaleValue), 32'h0);
        check("mid_rst_after_busy", 32'(busy), 32'h0);

        // Simultaneous requests 5 and 1
        done_base = done_cnt;
        audioRequest = 6'b100010;
        step();
        audioRequest = '0;
        check("dual_ps1", 32'(preScaleValue), 32'h14C);
        check("dual_id1", 32'(activeId), 32'h1);
        idle(9);
        sof_step();
        check("dual_f1", 32'(preScaleValue), 32'h14C);
        idle(9);
        sof_step();
        check("dual_end_ps", 32'(preScaleValue), 32'h0);
        check("dual_end_done", 32'(seqDone), 32'h1);
        step();
        check("dual_ps2", 32'(preScaleValue), 32'h117);
        check("dual_id2", 32'(activeId), 32'h5);
        check("dual_done_low", 32'(seqDone), 32'h0);
        idle(8);
        sof_step();
        check("dual_f2", 32'(preScaleValue), 32'h117);
        idle(9);
        sof_step();
        check("dual_end2_ps", 32'(preScaleValue), 32'h0);
        idle(3);
        check("dual_done_cnt", 32'(done_cnt - done_base), 32'h2);

        // Preemption of HOLE on note 2 by ENTER
        done_base = done_cnt;
        request(3);
        idle(9);
        for (int f = 0; f < 8; f++) begin
            sof_step();
            idle(9);
        end
        check("pre_before_id", 32'(activeId), 32'h3);
        check("pre_before_ps", 32'(preScaleValue), 32'h175);
        request(0);
        check("pre_ps", 32'(preScaleValue), 32'h175);
        check("pre_id", 32'(activeId), 32'h0);
        idle(9);
        sof_step();
        idle(9);
        sof_step();
        check("pre_end_done", 32'(seqDone), 32'h1);
        idle(20);
        check("pre_no_resume_ps", 32'(preScaleValue), 32'h0);
        check("pre_no_resume_busy", 32'(busy), 32'h0);
        check("pre_done_cnt", 32'(done_cnt - done_base), 32'h1);

        // Retrigger BALL after one frame
        request(5);
        idle(9);
        sof_step();
        idle(4);
        request(5);
        check("rtg_ps", 32'(preScaleValue), 32'h117);
        idle(4);
        sof_step();
        check("rtg_f1", 32'(preScaleValue), 32'h117);
        check("rtg_f1_busy", 32'(busy), 32'h1);
        idle(9);
        sof_step();
        check("rtg_end_ps", 32'(preScaleValue), 32'h0);
        check("rtg_end_done", 32'(seqDone), 32'h1);
        idle(3);
        check("rtg_no_pend", 32'(busy), 32'h0);

        // Mute during KEY_Y
        mute = 1'b1;
        request(2);
        check("mute_ps", 32'(preScaleValue), 32'h0);
        check("mute_busy", 32'(busy), 32'h1);
        check("mute_id", 32'(activeId), 32'h2);
        idle(9);
        sof_step();
        check("mute_f1_ps", 32'(preScaleValue), 32'h0);
        check("mute_f1_busy", 32'(busy), 32'h1);
        mute = 1'b0;
        step();
        check("unmute_ps", 32'(preScaleValue), 32'h128);
        idle(8);
        sof_step();
        check("mute_end_done", 32'(seqDone), 32'h1);
        check("mute_end_busy", 32'(busy), 32'h0);

        // startOfFrame coincident with launch does not shorten the note
        startOfFrame = 1'b1;
        request(4);
        startOfFrame = 1'b0;
        check("sofl_ps", 32'(preScaleValue), 32'h18B);
        idle(9);
        sof_step();
        check("sofl_f1", 32'(preScaleValue), 32'h18B);
        check("sofl_f1_done", 32'(seqDone), 32'h0);
        idle(9);
        sof_step();
        check("sofl_end_ps", 32'(preScaleValue), 32'h0);
        check("sofl_end_done", 32'(seqDone), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tone_sequencer
`default_nettype wire
